// File: rtl/visual_peak_history_multi.sv
// Scrolling multi-channel peak-history display: per-channel circular sample history drawn as
// bars or dots, with a per-channel peak-hold marker, two-stage pixel pipeline on the pixel clock.
module visual_peak_history_multi #(
    parameter int NCH     = 2,
    parameter int SEQ_LEN = 64,
    parameter int BAR_W   = 8,
    parameter int X0      = 64,
    parameter int LANE_Y0 = 160,
    parameter int LANE_H  = 160,
    parameter int HOLD_FR = 26,
    parameter int DECAY   = 2
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [9:0]        iX,
    input  logic [9:0]        iY,
    input  logic [NCH*15-1:0] iPeak,
    input  logic              iSampleStb,
    input  logic              iFrameStb,
    input  logic              iMode,
    input  logic              iFreeze,
    output logic [9:0]        oR,
    output logic [9:0]        oG,
    output logic [9:0]        oB,
    output logic              oReady
);

    localparam int AW = $clog2(SEQ_LEN);
    localparam int BW = $clog2(BAR_W);
    localparam int CW = $clog2(HOLD_FR + 1);
    localparam logic [10:0] XLO = 11'(X0);
    localparam logic [10:0] XHI = 11'(X0 + SEQ_LEN * BAR_W);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} stateT;

    stateT          state, stateNext;
    logic [AW-1:0]  clrAddr, wptr, wrAddr, rdAddr;
    logic           run, push, frame, wrEn;

    always_ff @(posedge iCLK) begin
        if (iRST) state <= CLEAR;
        else      state <= stateNext;
    end

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        stateNext = state;
        run       = 1'b0;
        oReady    = 1'b0;
        case (state)
            CLEAR: if (clrAddr == AW'(SEQ_LEN - 1)) stateNext = RUN;
            RUN: begin
                run    = 1'b1;
                oReady = 1'b1;
            end
            default: stateNext = CLEAR;
        endcase
    end

    assign push   = run & iSampleStb & ~iFreeze;
    assign frame  = run & iFrameStb;
    assign wrEn   = ~run | push;
    assign wrAddr = run ? wptr : clrAddr;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            clrAddr <= '0;
            wptr    <= '0;
        end else begin
            if (!run) clrAddr <= clrAddr + AW'(1);
            if (push) wptr    <= wptr + AW'(1);
        end
    end

    logic [6:0] hist   [NCH][SEQ_LEN];
    logic [6:0] rdData [NCH];

    // NOTE: the history RAM has no reset; the CLEAR sweep zeroes it so it can map onto block RAM.
    always_ff @(posedge iCLK) begin
        for (int c = 0; c < NCH; c++) begin
            if (wrEn) hist[c][wrAddr] <= run ? iPeak[15*c+8 +: 7] : 7'd0;
            rdData[c] <= hist[c][rdAddr];
        end
    end

    // Stage 1: column address, region flag and per-lane distance above the baseline.
    logic [10:0]        xExt;
    logic [9:0]         xOff;
    logic               inRegion;
    logic signed [11:0] delta   [NCH];
    logic signed [11:0] s1Delta [NCH];
    logic               s1Valid;

    always_comb begin
        xExt     = {1'b0, iX};
        inRegion = (xExt >= XLO) && (xExt < XHI);
        xOff     = iX - XLO[9:0];
        rdAddr   = wptr + xOff[AW+BW-1:BW];
        for (int c = 0; c < NCH; c++) begin
            delta[c] = 12'(LANE_Y0 + c * LANE_H) - {2'b00, iY};
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) s1Valid <= 1'b0;
        else      s1Valid <= run & inRegion;
    end

    always_ff @(posedge iCLK) begin
        s1Delta <= delta;
    end

    logic [6:0]    hold    [NCH];
    logic [CW-1:0] holdCnt [NCH];
    logic          modeQ;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            modeQ <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                hold[c]    <= '0;
                holdCnt[c] <= '0;
            end
        end else begin
            if (frame) modeQ <= iMode;
            for (int c = 0; c < NCH; c++) begin
                if (push && iPeak[15*c+8 +: 7] >= hold[c]) begin
                    hold[c]    <= iPeak[15*c+8 +: 7];
                    holdCnt[c] <= CW'(HOLD_FR);
                end else if (frame) begin
                    if (holdCnt[c] != '0) holdCnt[c] <= holdCnt[c] - CW'(1);
                    else hold[c] <= (hold[c] > 7'(DECAY)) ? hold[c] - 7'(DECAY) : 7'd0;
                end
            end
        end
    end

    // Stage 2: per-lane hit test, then lanes sharing a colour are summed with saturation.
    logic signed [11:0] hExt    [NCH];
    logic               bar     [NCH];
    logic               mark    [NCH];
    logic [9:0]         contrib [NCH];
    logic [12:0]        sum     [3];
    logic [9:0]         level   [3];

    always_comb begin
        for (int k = 0; k < 3; k++) sum[k] = '0;
        for (int c = 0; c < NCH; c++) begin
            hExt[c] = $signed({5'b00000, rdData[c]});
            mark[c] = (hold[c] != 7'd0) && (s1Delta[c] == $signed({5'b00000, hold[c]}));
            if (modeQ) bar[c] = (rdData[c] != 7'd0) && (s1Delta[c] == hExt[c] - 12'sd1);
            else       bar[c] = (s1Delta[c] >= 12'sd0) && (s1Delta[c] < hExt[c]);
            contrib[c] = mark[c] ? 10'h3FF : (bar[c] ? {rdData[c], 3'b000} : 10'd0);
            sum[c % 3] = sum[c % 3] + 13'(contrib[c]);
        end
        for (int k = 0; k < 3; k++) begin
            level[k] = (sum[k] > 13'd1023) ? 10'h3FF : sum[k][9:0];
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oR <= '0;
            oG <= '0;
            oB <= '0;
        end else begin
            oR <= s1Valid ? level[0] : 10'd0;
            oG <= s1Valid ? level[1] : 10'd0;
            oB <= s1Valid ? level[2] : 10'd0;
        end
    end

endmodule

// File: tb/tb_visual_peak_history_multi.sv
// Bench for visual_peak_history_multi: constant vectors, hand sequences and randomized traffic
// checked against a queue-based model of the scrolling history, holds and draw rules.
module tb_visual_peak_history_multi;

    localparam int NCH     = 4;
    localparam int SEQ_LEN = 64;
    localparam int BAR_W   = 8;
    localparam int X0      = 64;
    localparam int LANE_Y0 = 160;
    localparam int LANE_H  = 160;
    localparam int HOLD_FR = 26;
    localparam int DECAY   = 2;

    logic              iCLK = 1'b0;
    logic              iRST;
    logic [9:0]        iX, iY;
    logic [NCH*15-1:0] iPeak;
    logic              iSampleStb, iFrameStb, iMode, iFreeze;
    logic [9:0]        oR, oG, oB, oR2, oG2, oB2;
    logic              oReady, oReady2;

    visual_peak_history_multi #(.NCH(NCH)) dut (
        .iCLK(iCLK), .iRST(iRST), .iX(iX), .iY(iY), .iPeak(iPeak),
        .iSampleStb(iSampleStb), .iFrameStb(iFrameStb), .iMode(iMode), .iFreeze(iFreeze),
        .oR(oR), .oG(oG), .oB(oB), .oReady(oReady)
    );

    // Tight lane spacing so bars of lanes 0 and 3 overlap and the red sum saturates.
    visual_peak_history_multi #(.NCH(NCH), .LANE_H(32)) dut2 (
        .iCLK(iCLK), .iRST(iRST), .iX(iX), .iY(iY), .iPeak(iPeak),
        .iSampleStb(iSampleStb), .iFrameStb(iFrameStb), .iMode(iMode), .iFreeze(iFreeze),
        .oR(oR2), .oG(oG2), .oB(oB2), .oReady(oReady2)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int x, y, r, g, b;
    } vecT;

    // Reference model: history as a list of the last SEQ_LEN samples, newest at the back.
    int hist [NCH][$];
    int holdM[NCH];
    int cntM [NCH];
    int modeM;

    int qx[$], qy[$], qr[$], qg[$], qb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_pix(input string name, input int x, input int y,
                             input logic [9:0] ar, input logic [9:0] ag, input logic [9:0] ab,
                             input int r, input int g, input int b);
        total++;
        if ({ar, ag, ab} !== {10'(r), 10'(g), 10'(b)}) begin
            bad++;
            $display("FAIL %s at (%0d,%0d): got r=%0d g=%0d b=%0d want r=%0d g=%0d b=%0d",
                     name, x, y, ar, ag, ab, r, g, b);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            hist[c].delete();
            for (int i = 0; i < SEQ_LEN; i++) hist[c].push_back(0);
            holdM[c] = 0;
            cntM[c]  = 0;
        end
        modeM = 0;
    endfunction

    function automatic void model_step(input bit smp, input bit frm);
        bit take;
        take = smp && !iFreeze;
        for (int c = 0; c < NCH; c++) begin
            logic [NCH*15-1:0] t;
            int s;
            t = iPeak >> (15 * c + 8);
            s = int'(t[6:0]);
            if (take && s >= holdM[c]) begin
                holdM[c] = s;
                cntM[c]  = HOLD_FR;
            end else if (frm) begin
                if (cntM[c] > 0) cntM[c]--;
                else holdM[c] = (holdM[c] > DECAY) ? holdM[c] - DECAY : 0;
            end
            if (take) begin
                hist[c].push_back(s);
                void'(hist[c].pop_front());
            end
        end
        if (frm) modeM = int'(iMode);
    endfunction

    function automatic void model_pix(input int x, input int y, output int r, output int g, output int b);
        int s[3];
        s = '{0, 0, 0};
        if (x >= X0 && x < X0 + SEQ_LEN * BAR_W) begin
            int col;
            col = (x - X0) / BAR_W;
            for (int c = 0; c < NCH; c++) begin
                int base, h, v;
                base = LANE_Y0 + c * LANE_H;
                h    = hist[c][col];
                v    = 0;
                if (holdM[c] > 0 && y == base - holdM[c]) v = 1023;
                else if (modeM == 0 && y > base - h && y <= base) v = h * 8;
                else if (modeM == 1 && h > 0 && y == base - h + 1) v = h * 8;
                s[c % 3] += v;
            end
        end
        r = (s[0] > 1023) ? 1023 : s[0];
        g = (s[1] > 1023) ? 1023 : s[1];
        b = (s[2] > 1023) ? 1023 : s[2];
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_peak(input int c, input int h);
        iPeak[15*c +: 15] = 15'((h << 8) | int'($urandom_range(0, 255)));
    endtask

    task automatic set_all(input int h0, input int h1, input int h2, input int h3);
        set_peak(0, h0);
        set_peak(1, h1);
        set_peak(2, h2);
        set_peak(3, h3);
    endtask

    task automatic step(input bit smp, input bit frm);
        iSampleStb = smp;
        iFrameStb  = frm;
        tick();
        model_step(smp, frm);
        iSampleStb = 1'b0;
        iFrameStb  = 1'b0;
    endtask

    task automatic cmp_front(input string name);
        check_pix(name, qx.pop_front(), qy.pop_front(), oR, oG, oB,
                  qr.pop_front(), qg.pop_front(), qb.pop_front());
    endtask

    // One pixel per clock; the output seen now belongs to the pixel driven two clocks ago.
    task automatic stream_pix(input string name, input int x, input int y);
        int r, g, b;
        if (qr.size() == 2) cmp_front(name);
        iX = 10'(x);
        iY = 10'(y);
        model_pix(x, y, r, g, b);
        qx.push_back(x); qy.push_back(y);
        qr.push_back(r); qg.push_back(g); qb.push_back(b);
        tick();
    endtask

    task automatic drain(input string name);
        while (qr.size() > 0) begin
            if (qr.size() == 2) begin
                cmp_front(name);
                tick();
            end else begin
                cmp_front(name);
            end
        end
    endtask

    task automatic scan(input string name, input int x0, input int x1, input int xs,
                        input int y0, input int y1, input int ys);
        for (int y = y0; y <= y1; y += ys)
            for (int x = x0; x <= x1; x += xs)
                stream_pix(name, x, y);
        drain(name);
    endtask

    task automatic pix_const(input string name, input int sel, input int x, input int y,
                             input int r, input int g, input int b);
        iX = 10'(x);
        iY = 10'(y);
        tick();
        tick();
        if (sel == 0) check_pix(name, x, y, oR, oG, oB, r, g, b);
        else          check_pix(name, x, y, oR2, oG2, oB2, r, g, b);
    endtask

    task automatic pix_r(input string name, input int x, input int y, input int r);
        iX = 10'(x);
        iY = 10'(y);
        tick();
        tick();
        check($sformatf("%s(%0d,%0d)", name, x, y), oR, r);
    endtask

    // Strobes are held active during CLEAR to show they are ignored there.
    task automatic reset_and_wait();
        int n;
        iRST = 1'b1;
        iSampleStb = 1'b0; iFrameStb = 1'b0; iMode = 1'b0; iFreeze = 1'b0;
        iX = 10'd69; iY = 10'd150;
        set_all(100, 100, 100, 100);
        repeat (3) tick();
        check("reset_rgb", {oR, oG, oB}, 0);
        check("reset_ready", oReady, 0);
        iRST = 1'b0;
        iSampleStb = 1'b1; iFrameStb = 1'b1; iMode = 1'b1;
        model_reset();
        n = 0;
        while (!oReady && n < 200) begin
            tick();
            n++;
            if (n == 32) check("clear_rgb", {oR, oG, oB}, 0);
        end
        iSampleStb = 1'b0; iFrameStb = 1'b0; iMode = 1'b0;
        check("ready_latency", n, SEQ_LEN);
        check("ready2", oReady2, 1);
    endtask

    vecT tbl[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        iPeak = '0;
        // Test 1: reset, clear sweep, blank image.
        reset_and_wait();
        scan("blank", 0, 1023, 7, 0, 1023, 23);

        // Test 2: 64 columns of h=40 on lane 0 and h=32 on lane 1, holds decayed away.
        for (int i = 0; i < SEQ_LEN; i++) begin
            set_all(40, 32, 0, 0);
            step(1'b1, 1'b0);
        end
        repeat (50) step(1'b0, 1'b1);
        tbl[0]  = '{69, 150, 320, 0, 0};
        tbl[1]  = '{69, 120, 0, 0, 0};
        tbl[2]  = '{63, 150, 0, 0, 0};
        tbl[3]  = '{69, 160, 320, 0, 0};
        tbl[4]  = '{69, 161, 0, 0, 0};
        tbl[5]  = '{69, 121, 320, 0, 0};
        tbl[6]  = '{575, 150, 320, 0, 0};
        tbl[7]  = '{576, 150, 0, 0, 0};
        tbl[8]  = '{69, 300, 0, 256, 0};
        tbl[9]  = '{69, 288, 0, 0, 0};
        tbl[10] = '{69, 289, 0, 256, 0};
        tbl[11] = '{69, 320, 0, 256, 0};
        for (int i = 0; i < 12; i++)
            pix_const($sformatf("vec%0d", i), 0, tbl[i].x, tbl[i].y, tbl[i].r, tbl[i].g, tbl[i].b);

        // Test 3: 70 ramp samples wrap the history.
        for (int n = 0; n < 70; n++) begin
            set_all(n, 0, 0, 0);
            step(1'b1, 1'b0);
        end
        pix_r("ramp_right_base", 568, 160, 552);
        pix_r("ramp_right_top", 568, 92, 552);
        pix_r("ramp_marker", 568, 91, 1023);
        pix_r("ramp_above", 568, 90, 0);
        pix_r("ramp_left_base", 64, 160, 48);
        pix_r("ramp_left_top", 64, 155, 48);
        pix_r("ramp_left_above", 64, 154, 0);
        pix_r("ramp_col1", 72, 154, 56);
        scan("ramp", 60, 580, 11, 80, 170, 3);

        // Randomized traffic against the model.
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 300; i++) begin
                for (int c = 0; c < NCH; c++) set_peak(c, $urandom_range(0, 127));
                iMode   = 1'($urandom_range(0, 1));
                iFreeze = ($urandom_range(0, 9) == 0);
                step(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
            end
            iFreeze = 1'b0;
            for (int i = 0; i < 800; i++)
                stream_pix("random", $urandom_range(40, 600), $urandom_range(0, 700));
            drain("random");
        end

        // Test 4: hold marker timing, decay and reload by a coincident sample.
        iMode = 1'b0;
        iFreeze = 1'b0;
        set_all(0, 0, 0, 0);
        repeat (100) step(1'b0, 1'b1);
        set_all(100, 0, 0, 0);
        step(1'b1, 1'b0);
        set_all(0, 0, 0, 0);
        step(1'b1, 1'b0);
        pix_r("hold_k0", 64, 60, 1023);
        for (int k = 1; k <= 30; k++) begin
            int hexp;
            step(1'b0, 1'b1);
            hexp = (k <= HOLD_FR) ? 100 : 100 - DECAY * (k - HOLD_FR);
            pix_r($sformatf("hold_k%0d", k), 64, LANE_Y0 - hexp, 1023);
        end
        set_all(100, 0, 0, 0);
        step(1'b1, 1'b1);
        set_all(0, 0, 0, 0);
        for (int j = 1; j <= 30; j++) begin
            int hexp;
            step(1'b0, 1'b1);
            hexp = (j <= HOLD_FR) ? 100 : 100 - DECAY * (j - HOLD_FR);
            pix_r($sformatf("reload_j%0d", j), 64, LANE_Y0 - hexp, 1023);
        end
        scan("hold_column", 64, 64, 1, 0, 200, 1);

        // Test 5: mode is latched on frame strobe only; freeze ignores samples.
        set_all(50, 0, 0, 0);
        step(1'b1, 1'b0);
        iMode = 1'b1;
        pix_r("mode_pending", 568, 150, 400);
        step(1'b0, 1'b1);
        pix_r("dot_mid", 568, 150, 0);
        pix_r("dot_top", 568, 111, 400);
        pix_r("dot_above", 568, 110, 0);
        iFreeze = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_all(127, $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
            step(1'b1, 1'b0);
        end
        pix_r("freeze_dot", 568, 111, 400);
        pix_r("freeze_hold", 64, 70, 1023);
        scan("freeze", 40, 580, 13, 0, 170, 1);
        iFreeze = 1'b0;
        iMode = 1'b0;
        step(1'b0, 1'b1);

        // Test 6: all lanes full height; second instance overlaps lanes 0 and 3.
        for (int i = 0; i < SEQ_LEN; i++) begin
            set_all(127, 127, 127, 127);
            step(1'b1, 1'b0);
        end
        pix_const("full_lane0", 0, 64, 150, 1016, 0, 0);
        pix_const("full_lane3", 0, 64, 600, 1016, 0, 0);
        pix_const("sat_overlap", 1, 64, 150, 1023, 1016, 1016);
        pix_const("sat_lane3_only", 1, 64, 250, 1016, 0, 0);
        pix_const("sat_marker0", 1, 64, 33, 1023, 0, 0);
        pix_const("sat_marker3", 1, 64, 129, 1023, 1016, 1016);
        scan("full", 60, 580, 17, 0, 700, 9);

        // Reset while running returns to CLEAR from address 0.
        reset_and_wait();
        scan("rerun_blank", 40, 600, 9, 0, 700, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
